// File: rtl/exp_backoff_multi.sv
// exp_backoff_multi: per-channel exponential backoff with LFSR-randomised wait counts and retry limit
module exp_backoff_multi #(
  parameter int          NumChannels = 4,
  parameter logic [15:0] Seed        = 16'hFFFF,
  parameter int          MaxExp      = 16,
  parameter int          MinExp      = 0,
  parameter int          MaxRetries  = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumChannels-1:0]         set_i,
  input  logic [NumChannels-1:0]         clr_i,
  input  logic [$clog2(MaxExp+1)-1:0]    max_exp_i,
  output logic [NumChannels-1:0]         ready_o,
  output logic [NumChannels-1:0]         failed_o
);
  localparam int EW = $clog2(MaxExp + 1);
  localparam logic [EW-1:0] MinE = EW'(MinExp);
  localparam logic [EW-1:0] MaxE = EW'(MaxExp);
  localparam logic [MaxExp-1:0] Floor = MaxExp'((17'd1 << MinExp) - 17'd1);
  localparam logic [31:0] SeedDbl = {Seed, Seed};
  if (MaxExp < 1 || MaxExp > 16) begin : g_bad_max_exp
    $error("MaxExp must be within 1..16");
  end
  if (MinExp < 0 || MinExp > MaxExp) begin : g_bad_min_exp
    $error("MinExp must be within 0..MaxExp");
  end
  if (Seed == 16'h0000) begin : g_bad_seed
    $error("Seed must be non-zero");
  end
  logic [EW-1:0]     eff_exp;
  logic [MaxExp-1:0] cap;
  // runtime cap clamped into [MinExp, MaxExp], shared by all channels
  always_comb begin
    eff_exp = max_exp_i < MinE ? MinE : (max_exp_i > MaxE ? MaxE : max_exp_i);
    cap     = MaxExp'((17'd1 << eff_exp) - 17'd1);
  end
  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    localparam logic [15:0] ChSeed = SeedDbl[31-(g%16) -: 16];
    logic [15:0]       lfsr_q;
    logic [15:0]       retry_q;
    logic [MaxExp-1:0] mask_q;
    logic [MaxExp-1:0] cnt_q;
    logic [MaxExp-1:0] mask_d;
    logic              failed_q;
    logic              hit;
    // widen the mask by one bit per failed trial, held between the floor and the cap
    always_comb begin
      mask_d = ((mask_q << 1) | MaxExp'(1) | Floor) & cap;
      hit    = (MaxRetries != 0) && (({1'b0, retry_q} + 17'd1) == 17'(MaxRetries));
    end
    // channel state: clr beats set beats count-down; LFSR steps on every set pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr_q   <= ChSeed;
        mask_q   <= '0;
        cnt_q    <= '0;
        retry_q  <= '0;
        failed_q <= 1'b0;
      end else begin
        if (set_i[g]) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        if (clr_i[g]) begin
          mask_q   <= '0;
          cnt_q    <= '0;
          retry_q  <= '0;
          failed_q <= 1'b0;
        end else if (set_i[g] && !failed_q) begin
          mask_q   <= mask_d;
          retry_q  <= retry_q + 16'(retry_q != 16'hFFFF);
          failed_q <= hit;
          cnt_q    <= hit ? '0 : (mask_d & lfsr_q[MaxExp-1:0]);
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
    assign ready_o[g]  = (cnt_q == '0) && !failed_q;
    assign failed_o[g] = failed_q;
  end
endmodule

// File: tb/tb_exp_backoff_multi.sv
// tb_exp_backoff_multi: scoreboard bench against a wait-level reference model
module tb_exp_backoff_multi;
  localparam int NC = 4;
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam int MAXE = 16;
  localparam int MINE = 1;
  localparam int MR = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] set_v = '0;
  logic [NC-1:0] clr_v = '0;
  logic [4:0] mexp = 5'd16;
  logic [NC-1:0] ready;
  logic [NC-1:0] failed;
  int passed = 0;
  int total = 0;
  logic [7:0] sb[$];
  int m_lfsr[NC];
  int m_lvl[NC];
  int m_cnt[NC];
  int m_retry[NC];
  bit m_fail[NC];
  exp_backoff_multi #(.NumChannels(NC), .Seed(SEED), .MaxExp(MAXE), .MinExp(MINE), .MaxRetries(MR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .set_i(set_v), .clr_i(clr_v), .max_exp_i(mexp),
    .ready_o(ready), .failed_o(failed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask
  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (fb << 15);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_lfsr[i] = ((int'(SEED) << i) | (int'(SEED) >> (16 - i))) & 16'hFFFF;
      m_lvl[i] = 0;
      m_cnt[i] = 0;
      m_retry[i] = 0;
      m_fail[i] = 0;
    end
  endtask
  function automatic logic [7:0] model_out();
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < NC; i++) begin
      o[i] = (m_cnt[i] == 0) && !m_fail[i];
      o[4+i] = m_fail[i];
    end
    return o;
  endfunction
  task automatic model_step(input logic [NC-1:0] s, input logic [NC-1:0] c, input int m);
    int e;
    int old;
    e = m < MINE ? MINE : (m > MAXE ? MAXE : m);
    for (int i = 0; i < NC; i++) begin
      old = m_lfsr[i];
      if (s[i]) m_lfsr[i] = lfsr_step(old);
      if (c[i]) begin
        m_lvl[i] = 0; m_cnt[i] = 0; m_retry[i] = 0; m_fail[i] = 0;
      end else if (s[i] && !m_fail[i]) begin
        m_lvl[i] = (m_lvl[i] + 1 < MINE) ? MINE : m_lvl[i] + 1;
        if (m_lvl[i] > e) m_lvl[i] = e;
        m_cnt[i] = old % (1 << m_lvl[i]);
        m_retry[i]++;
        if (MR != 0 && m_retry[i] == MR) begin
          m_fail[i] = 1;
          m_cnt[i] = 0;
        end
      end else if (m_cnt[i] > 0) m_cnt[i]--;
    end
  endtask
  task automatic cycle(input logic [NC-1:0] s, input logic [NC-1:0] c, input logic [4:0] m);
    @(negedge clk);
    set_v = s;
    clr_v = c;
    mexp = m;
    @(posedge clk);
    #1;
    model_step(s, c, int'(m));
    sb.push_back(model_out());
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, mexp);
  endtask
  task automatic first_seq();
    cycle(4'b0001, '0, 5'd16);
    idle(2);
    cycle(4'b0001, '0, 5'd16);
    idle(4);
    cycle(4'b0001, '0, 5'd16);
  endtask
  // monitor: compare each registered output snapshot with the model's prediction
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ready", 32'(ready), 32'(e[3:0]));
        chk("failed", 32'(failed), 32'(e[7:4]));
      end
    end
  end
  initial begin
    model_reset();
    #3;
    chk("reset_ready", 32'(ready), 32'hF);
    chk("reset_failed", 32'(failed), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    first_seq();
    idle(2);
    @(negedge clk);
    #2;
    chk("counting_before_reset", 32'(ready[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", 32'(ready), 32'hF);
    chk("async_reset_failed", 32'(failed), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    first_seq();
    idle(8);
    cycle(4'b0000, 4'b0001, 5'd2);
    for (int i = 0; i < 6; i++) cycle(4'b0001, '0, 5'd2);
    idle(4);
    cycle('0, 4'b0001, 5'd0);
    cycle(4'b0001, '0, 5'd0);
    idle(2);
    cycle('0, 4'b0100, 5'd16);
    for (int i = 0; i < MR + 1; i++) cycle(4'b0100, '0, 5'd16);
    idle(2);
    cycle('0, 4'b0100, 5'd16);
    idle(1);
    cycle('0, 4'b0001, 5'd16);
    cycle(4'b0001, '0, 5'd16);
    cycle(4'b0001, '0, 5'd16);
    cycle(4'b0001, '0, 5'd16);
    cycle(4'b0001, 4'b0001, 5'd16);
    idle(2);
    cycle(4'b0011, '0, 5'd16);
    idle(3);
    for (int i = 0; i < 600; i++) begin
      logic [NC-1:0] s, c;
      for (int j = 0; j < NC; j++) begin
        s[j] = ($urandom_range(0, 2) == 0);
        c[j] = ($urandom_range(0, 15) == 0);
      end
      cycle(s, c, 5'($urandom_range(0, 20)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    idle(2);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
